vga_pixel_fetch: RTL

- Upstream stage of the VGA timing driver. Prefetches pixels in raster order from an external framebuffer RAM with fixed read latency.
- Buffers the pixels in a small FIFO and hands one 12-bit RGB pixel to the driver per visible-pixel request.
- Restarts at framebuffer address 0 on each frame-start pulse from the driver.
- Runs entirely in the pixel clock domain.

---
 rtl/vga_pixel_fetch_if.sv | 11 +
 rtl/vga_pixel_fetch.sv | 74 +++++++
 2 files changed

// File: rtl/vga_pixel_fetch_if.sv
// vga_pixel_fetch_if: driver-side pixel handshake and framebuffer read port of the pixel fetcher.
interface vga_pixel_fetch_if #(parameter int ADDR_W = 19, PIX_W = 12, LVL_W = 5);
  logic frame_start, pix_req, pix_valid, fb_rd, underflow;
  logic [PIX_W-1:0] pix_data, fb_rdata;
  logic [ADDR_W-1:0] fb_addr;
  logic [LVL_W-1:0] fifo_level;
  modport master (output frame_start, pix_req, fb_rdata,
                  input pix_data, pix_valid, fb_rd, fb_addr, fifo_level, underflow);
  modport slave (input frame_start, pix_req, fb_rdata,
                 output pix_data, pix_valid, fb_rd, fb_addr, fifo_level, underflow);
endinterface

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: prefetches framebuffer pixels in raster order into a FIFO and hands one per request.
module vga_pixel_fetch #(
  parameter int H_VISIBLE_AREA = 800,
  parameter int V_VISIBLE_AREA = 600,
  parameter int FRAME_PIXELS = H_VISIBLE_AREA * V_VISIBLE_AREA,
  parameter int ADDR_W = $clog2(FRAME_PIXELS),
  parameter int PIX_W = 12,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 16
) (
  input logic vga_clk,
  input logic reset,
  vga_pixel_fetch_if.slave bus
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [PIX_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [RD_LATENCY-1:0] inflight;
  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0] pix_data;
  logic [LW:0] credit;
  logic done, rd, push, pop, last, pix_valid, underflow;
  // Occupancy plus outstanding reads bounds the FIFO, so a returning read always has room.
  always_comb begin
    credit = {1'b0, level};
    for (int i = 0; i < RD_LATENCY; i++) credit = credit + (LW+1)'(inflight[i]);
  end
  assign rd = !reset && !bus.frame_start && !done && credit < (LW+1)'(FIFO_DEPTH);
  assign push = inflight[RD_LATENCY-1];
  assign pop = bus.pix_req && level != '0;
  assign last = addr == ADDR_W'(FRAME_PIXELS - 1);
  assign bus.fb_rd = rd;
  assign bus.fb_addr = addr;
  assign bus.fifo_level = level;
  assign bus.pix_data = pix_data;
  assign bus.pix_valid = pix_valid;
  assign bus.underflow = underflow;
  always_ff @(posedge vga_clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      inflight <= '0;
      addr <= '0;
      done <= 1'b0;
      pix_data <= '0;
      pix_valid <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.frame_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      inflight <= '0;
      addr <= '0;
      done <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      inflight <= RD_LATENCY'({inflight, rd});
      if (rd) begin
        addr <= last ? addr : addr + ADDR_W'(1);
        done <= last;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(push) - LW'(pop);
      pix_valid <= pop;
      if (bus.pix_req) pix_data <= pop ? mem[rd_ptr] : '0;
      if (bus.pix_req && !pop) underflow <= 1'b1;
    end
  always_ff @(posedge vga_clk)
    if (push && !bus.frame_start) mem[wr_ptr] <= bus.fb_rdata;
endmodule
